// File: rtl/usb_phy_pkg.sv
// Shared USB PHY receive-side definitions: symbol width, K28.5 patterns and
// the comma-alignment state encoding.
package usb_phy_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] COMMA_RDN = 10'h0FA;
  localparam logic [SYM_W-1:0] COMMA_RDP = 10'h305;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    CHECK    = 2'd1,
    LOCKED   = 2'd2
  } align_state_e;

endpackage

// File: rtl/usb_comma_detect.sv
// Combinational K28.5 search over a 20-bit window: flags every bit offset
// holding a comma and reports the lowest such offset.
module usb_comma_detect #(
  parameter logic [9:0] COMMA_RDN = usb_phy_pkg::COMMA_RDN,
  parameter logic [9:0] COMMA_RDP = usb_phy_pkg::COMMA_RDP
) (
  input  logic [19:0] win,
  output logic [9:0]  match,
  output logic [3:0]  low_idx
);
  import usb_phy_pkg::*;

  // The top bit can never start or sit inside a 10-bit candidate.
  logic unused_win_msb;
  assign unused_win_msb = win[19];

  always_comb begin
    match = '0;
    for (int k = 0; k < SYM_W; k++) begin
      match[k] = (win[k +: SYM_W] == COMMA_RDN) || (win[k +: SYM_W] == COMMA_RDP);
    end
  end

  always_comb begin
    low_idx = '0;
    for (int k = SYM_W - 1; k >= 0; k--) begin
      if (match[k]) low_idx = 4'(k);
    end
  end

endmodule

// File: rtl/usb_comma_align.sv
// K28.5 symbol aligner: finds the comma in a {in, prev} window, locks the bit
// offset after repeated consistent commas and emits re-sliced 10-bit symbols.
module usb_comma_align #(
  parameter int         LOCK_CNT  = 3,
  parameter int         LOSS_CNT  = 4,
  parameter logic [9:0] COMMA_RDN = usb_phy_pkg::COMMA_RDN,
  parameter logic [9:0] COMMA_RDP = usb_phy_pkg::COMMA_RDP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in,
  input  logic       align_en,
  output logic [9:0] out,
  output logic       out_valid,
  output logic       comma_det,
  output logic       locked,
  output logic [3:0] offset
);
  import usb_phy_pkg::*;

  localparam logic [3:0] LOCK_TGT = 4'(LOCK_CNT);
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_CNT);

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'hF) ? c : c + 4'd1;
  endfunction

  function automatic logic is_comma(input logic [SYM_W-1:0] s);
    return (s == COMMA_RDN) || (s == COMMA_RDP);
  endfunction

  align_state_e state, state_nxt;
  logic [9:0]   prev;
  logic [19:0]  win;
  logic [9:0]   match;
  logic [3:0]   low_idx;
  logic [9:0]   slice;
  logic [3:0]   offset_nxt, good_cnt, good_nxt, bad_cnt, bad_nxt;
  logic         hit_cur, hit_any;

  assign win     = {in, prev};
  assign slice   = win[offset +: SYM_W];
  assign hit_cur = match[offset];
  assign hit_any = |match;

  usb_comma_detect #(
    .COMMA_RDN (COMMA_RDN),
    .COMMA_RDP (COMMA_RDP)
  ) u_detect (
    .win     (win),
    .match   (match),
    .low_idx (low_idx)
  );

  always_comb begin
    state_nxt  = state;
    offset_nxt = offset;
    good_nxt   = good_cnt;
    bad_nxt    = bad_cnt;
    if (align_en) begin
      case (state)
        UNLOCKED: begin
          if (hit_any) begin
            offset_nxt = low_idx;
            good_nxt   = 4'd1;
            if (LOCK_CNT == 1) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end else begin
              state_nxt = CHECK;
            end
          end
        end
        CHECK: begin
          // A comma at the current offset outranks any simultaneous foreign one.
          if (hit_cur) begin
            good_nxt = sat_inc(good_cnt);
            if (sat_inc(good_cnt) >= LOCK_TGT) begin
              state_nxt = LOCKED;
              bad_nxt   = '0;
            end
          end else if (hit_any) begin
            offset_nxt = low_idx;
            good_nxt   = 4'd1;
          end
        end
        LOCKED: begin
          if (hit_cur) begin
            bad_nxt = '0;
          end else if (hit_any) begin
            bad_nxt = sat_inc(bad_cnt);
            if (sat_inc(bad_cnt) >= LOSS_TGT) begin
              state_nxt = UNLOCKED;
              good_nxt  = '0;
            end
          end
        end
        default: state_nxt = UNLOCKED;
      endcase
    end
  end

  // Slice with the offset in force before this edge; a new offset applies next word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= UNLOCKED;
      prev      <= '0;
      out       <= '0;
      comma_det <= 1'b0;
      out_valid <= 1'b0;
      locked    <= 1'b0;
      offset    <= '0;
      good_cnt  <= '0;
      bad_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      prev      <= in;
      out       <= slice;
      comma_det <= is_comma(slice);
      out_valid <= (state_nxt == LOCKED);
      locked    <= (state_nxt == LOCKED);
      offset    <= offset_nxt;
      good_cnt  <= good_nxt;
      bad_cnt   <= bad_nxt;
    end
  end

endmodule

// File: tb/tb_usb_comma_align.sv
// Bench for usb_comma_align: serial bit-stream stimulus with commas placed at
// chosen bit phases, compared every cycle against a bit-level reference model.
module tb_usb_comma_align;

  localparam logic [9:0] RDN    = 10'h0FA;
  localparam logic [9:0] RDP    = 10'h305;
  localparam int         LOCK_N = 3;
  localparam int         LOSS_N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       align_en;
  logic [9:0] in;
  logic [9:0] out;
  logic       out_valid, comma_det, locked;
  logic [3:0] offset;

  always #5 clk = ~clk;

  usb_comma_align dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .align_en  (align_en),
    .out       (out),
    .out_valid (out_valid),
    .comma_det (comma_det),
    .locked    (locked),
    .offset    (offset)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: mode 0 = hunting, 1 = confirming, 2 = locked.
  bit [9:0] m_prev, m_out;
  bit       m_cd;
  int       m_mode, m_off, m_good, m_bad;

  bit sbits[$];
  bit fill_bit;

  task automatic m_reset();
    m_prev = '0; m_out = '0; m_cd = 1'b0;
    m_mode = 0; m_off = 0; m_good = 0; m_bad = 0;
    sbits.delete();
    fill_bit = 1'b0;
  endtask

  task automatic m_step(input bit [9:0] w, input bit en);
    bit       wb[20];
    bit [9:0] c;
    int       hits[$];
    bit       here;
    for (int i = 0; i < 10; i++) begin
      wb[i]      = m_prev[i];
      wb[i + 10] = w[i];
    end
    for (int k = 0; k < 10; k++) begin
      for (int b = 0; b < 10; b++) c[b] = wb[k + b];
      if (c == RDN || c == RDP) hits.push_back(k);
    end
    for (int b = 0; b < 10; b++) m_out[b] = wb[m_off + b];
    m_cd = (m_out == RDN) || (m_out == RDP);
    here = 1'b0;
    foreach (hits[i]) if (hits[i] == m_off) here = 1'b1;
    if (en && hits.size() > 0) begin
      if (m_mode == 0) begin
        m_off  = hits[0];
        m_good = 1;
        if (LOCK_N == 1) begin m_mode = 2; m_bad = 0; end
        else m_mode = 1;
      end else if (m_mode == 1) begin
        if (here) begin
          m_good = (m_good < 15) ? m_good + 1 : 15;
          if (m_good >= LOCK_N) begin m_mode = 2; m_bad = 0; end
        end else begin
          m_off  = hits[0];
          m_good = 1;
        end
      end else begin
        if (here) m_bad = 0;
        else begin
          m_bad = (m_bad < 15) ? m_bad + 1 : 15;
          if (m_bad >= LOSS_N) begin m_mode = 0; m_good = 0; end
        end
      end
    end
    m_prev = w;
  endtask

  task automatic step(input logic [9:0] w);
    in = w;
    @(posedge clk);
    #1;
    m_step(w, align_en);
    check_eq("out",       out,       m_out);
    check_eq("comma_det", comma_det, m_cd);
    check_eq("out_valid", out_valid, m_mode == 2);
    check_eq("locked",    locked,    m_mode == 2);
    check_eq("offset",    offset,    m_off[3:0]);
  endtask

  task automatic push_fill(input int n);
    repeat (n) begin
      fill_bit = ~fill_bit;
      sbits.push_back(fill_bit);
    end
  endtask

  task automatic push_sym(input logic [9:0] s);
    for (int b = 0; b < 10; b++) sbits.push_back(s[b]);
    fill_bit = s[9];
  endtask

  // The queue head is always word-aligned, so size mod 10 is the bit phase.
  task automatic push_comma(input int ph, input bit use_rdp);
    while ((sbits.size() % 10) != ph) push_fill(1);
    push_sym(use_rdp ? RDP : RDN);
  endtask

  task automatic drain_words();
    logic [9:0] w;
    while (sbits.size() >= 10) begin
      for (int b = 0; b < 10; b++) w[b] = sbits.pop_front();
      step(w);
    end
  endtask

  task automatic flush();
    while ((sbits.size() % 10) != 0) push_fill(1);
    push_fill(30);
    drain_words();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    in  = 10'h3FF;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out",       out,       10'h000);
    check_eq("rst_locked",    locked,    1'b0);
    check_eq("rst_offset",    offset,    4'd0);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_comma_det", comma_det, 1'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int  cur_ph;
    int  r, ph;
    bit  saw_rdp;
    rst      = 1'b0;
    align_en = 1'b1;
    in       = 10'h3FF;
    m_reset();

    // Reset, then a comma-free alternating stream.
    do_reset();
    repeat (40) step(10'h155);
    check_eq("nocomma_locked",    locked,    1'b0);
    check_eq("nocomma_out_valid", out_valid, 1'b0);

    // Aligned acquisition at offset 0, one comma every 4th word.
    do_reset();
    push_comma(0, 1'b0); push_fill(30);
    push_comma(0, 1'b0); flush();
    check_eq("aligned_two_locked", locked, 1'b0);
    check_eq("aligned_offset",     offset, 4'd0);
    push_comma(0, 1'b0); flush();
    check_eq("aligned_locked",    locked,    1'b1);
    check_eq("aligned_out_valid", out_valid, 1'b1);

    // Shifted acquisition at offset 6 with alternating disparity.
    do_reset();
    push_comma(6, 1'b0); push_comma(6, 1'b1); flush();
    check_eq("shift_two_locked", locked, 1'b0);
    check_eq("shift_offset_acq", offset, 4'd6);
    push_comma(6, 1'b0); flush();
    check_eq("shift_locked", locked, 1'b1);
    check_eq("shift_offset", offset, 4'd6);
    push_comma(6, 1'b1);
    while ((sbits.size() % 10) != 0) push_fill(1);
    push_fill(30);
    saw_rdp = 1'b0;
    while (sbits.size() >= 10) begin
      logic [9:0] w;
      for (int b = 0; b < 10; b++) w[b] = sbits.pop_front();
      step(w);
      if (out_valid && comma_det && out == RDP) saw_rdp = 1'b1;
    end
    check_eq("shift_rdp_symbol", saw_rdp, 1'b1);

    // Restart in CHECK: two commas at offset 2, then offset 5.
    do_reset();
    push_comma(2, 1'b0); push_fill(20); push_comma(2, 1'b1); flush();
    check_eq("restart_offset2", offset, 4'd2);
    check_eq("restart_locked2", locked, 1'b0);
    push_comma(5, 1'b0); push_comma(5, 1'b1); flush();
    check_eq("restart_offset5", offset, 4'd5);
    check_eq("restart_not_yet", locked, 1'b0);
    push_comma(5, 1'b0); flush();
    check_eq("restart_locked5", locked, 1'b1);

    // Loss of lock: foreign commas at offset 4, one realigning comma at 0.
    do_reset();
    repeat (3) push_comma(0, 1'b0);
    flush();
    check_eq("loss_acquire", locked, 1'b1);
    repeat (3) push_comma(4, 1'b1);
    flush();
    check_eq("loss_hold3", locked, 1'b1);
    push_comma(0, 1'b0); flush();
    repeat (3) push_comma(4, 1'b0);
    flush();
    check_eq("loss_bad_cleared", locked, 1'b1);
    push_comma(4, 1'b1); flush();
    check_eq("loss_unlocked",   locked, 1'b0);
    check_eq("loss_offset_kept", offset, 4'd0);

    // Freeze with align_en low while confirming.
    do_reset();
    push_comma(3, 1'b0); flush();
    check_eq("freeze_offset_acq", offset, 4'd3);
    align_en = 1'b0;
    repeat (5) push_comma(7, 1'b1);
    flush();
    check_eq("freeze_offset", offset, 4'd3);
    check_eq("freeze_locked", locked, 1'b0);
    align_en = 1'b1;
    push_comma(3, 1'b1); push_comma(3, 1'b0); flush();
    check_eq("freeze_resume_locked", locked, 1'b1);
    check_eq("freeze_resume_offset", offset, 4'd3);

    // Asynchronous reset between edges while locked.
    #2;
    rst = 1'b0;
    #1;
    check_eq("async_locked",    locked,    1'b0);
    check_eq("async_out",       out,       10'h000);
    check_eq("async_offset",    offset,    4'd0);
    check_eq("async_out_valid", out_valid, 1'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) push_comma(1, 1'b0);
    flush();
    check_eq("post_async_locked", locked, 1'b1);
    check_eq("post_async_offset", offset, 4'd1);

    // Randomized phases, disparities, data symbols and align_en toggling.
    do_reset();
    cur_ph = $urandom_range(0, 9);
    repeat (200) begin
      r = $urandom_range(0, 99);
      if (r < 8) align_en = ~align_en;
      ph = (r < 75) ? cur_ph : $urandom_range(0, 9);
      if (r >= 92) cur_ph = ph;
      if ($urandom_range(0, 3) == 0) push_sym(10'($urandom_range(0, 1023)));
      else push_comma(ph, 1'($urandom_range(0, 1)));
      push_fill($urandom_range(0, 25));
      drain_words();
    end
    align_en = 1'b1;
    flush();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/usb_comma_align.md
Name: usb_comma_align

Overview:
- Symbol-alignment stage directly downstream of the RX polarity register.
- Consumes the 10-bit raw (polarity-corrected) words it produces and searches a 20-bit sliding window for the K28.5 comma.
- Locks the symbol boundary after repeated consistent commas, then emits boundary-aligned 10-bit symbols to the 8b/10b decoder.

Parameters:
- LOCK_CNT, 3: consecutive commas at the same offset required to declare lock (legal range 1..15).
- LOSS_CNT, 4: consecutive commas seen only at a foreign offset that drop lock (legal range 1..15).
- COMMA_RDN, 10'h0FA: K28.5 running-disparity-negative pattern.
- COMMA_RDP, 10'h305: K28.5 running-disparity-positive pattern.

Ports:
- clk  input  1  RX symbol clock.
- rst  input  1  asynchronous active-low reset.
- in  input  10  raw word from the polarity register, one per clk.
- align_en  input  1  alignment search enable.
- out  output  10  aligned symbol.
- out_valid  output  1  high while LOCKED.
- comma_det  output  1  current out equals COMMA_RDN or COMMA_RDP.
- locked  output  1  state == LOCKED.
- offset  output  4  currently selected bit offset (0..9).

Behaviour:
- Reset: `rst` low asynchronously clears prev word, out, out_valid, comma_det, locked, offset, good_cnt and bad_cnt to 0; state goes to UNLOCKED.
- Window:
  - prev holds the previous `in`; W[19:0] = {in, prev}.
  - Candidate k (0..9) = W[k+9:k]; offset 0 selects prev exactly.
  - match[k] = 1 when candidate k equals COMMA_RDN or COMMA_RDP.
- Output path:
  - out <= W[offset+9:offset] registered each clk.
  - Latency from `in` to `out` is 2 clk at offset 0.
  - comma_det is registered alongside out and describes the same word.
  - out_valid and locked are registered; they reflect the state after the edge.
- State machine (state updates only when align_en=1; with align_en=0, state, counters and offset freeze while data keeps flowing):
  - UNLOCKED:
    - Any match: offset <= lowest set k, good_cnt <= 1.
    - Go to LOCKED if LOCK_CNT==1, else CHECK.
  - CHECK:
    - match[offset]: good_cnt++; reaching LOCK_CNT -> LOCKED, bad_cnt <= 0.
    - Match only at other offsets: offset <= lowest set k, good_cnt <= 1, stay in CHECK.
    - No match: hold.
  - LOCKED:
    - match[offset]: bad_cnt <= 0.
    - Match only at other offsets: bad_cnt++; reaching LOSS_CNT -> UNLOCKED (offset retained until the next acquisition).
    - No match: hold.
- Priority: if match[offset] and a foreign match are both set in the same cycle, the current offset wins and the event counts as aligned.
- Offset change: a change takes effect on the out word registered in the next cycle. No word is dropped or duplicated; the word at the switch edge is simply re-sliced.
- Counters:
  - 4-bit saturating; they never wrap.
  - good_cnt is cleared on every entry to UNLOCKED.
- Mid-operation:
  - `rst` assertion in any state returns to the reset values immediately.
  - align_en deassert then reassert resumes from the frozen state.
- out is don't-care-valid when out_valid=0. It still carries the sliced data; the decoder must ignore it.

Decomposition:
- Shared package usb_phy_pkg holds:
  - K28.5 constants COMMA_RDN/COMMA_RDP;
  - the align state enum {UNLOCKED, CHECK, LOCKED};
  - SYM_W=10.
- One natural sub-module, usb_comma_detect: combinational. Input 20-bit window; outputs the 10-bit match vector and the lowest-set index. Instantiated once.
- The FSM and slicing mux stay in usb_comma_align.

Test Plan:
- Reset and pass-through:
  - Stimulus: hold rst low, drive in=10'h3FF.
  - Required: out=0, locked=0, offset=0.
  - Stimulus: release rst, stream words with no comma.
  - Required: out_valid stays 0 and locked stays 0 indefinitely.
- Aligned acquisition:
  - Stimulus: stream 10'h0FA every 4th word at offset 0, defaults.
  - Required: locked rises one clk after the 3rd comma; out_valid=1; comma_det pulses 2 clk after each comma enters.
- Shifted acquisition:
  - Stimulus: serial stream with the comma straddling words at offset 6 (alternating RDN/RDP).
  - Required: offset=6 and lock after 3 commas; out carries exact 0x0FA/0x305 symbols.
- Restart in CHECK:
  - Stimulus: 2 commas at offset 2, then commas at offset 5.
  - Required: offset becomes 5, good_cnt restarts at 1, lock only after 3 commas at offset 5.
- Loss of lock:
  - Stimulus: once locked at offset 0, send 3 commas at offset 4, then 1 at offset 0, then 4 at offset 4.
  - Required: locked stays 1 through the first 3; bad_cnt clears on the offset-0 comma; locked falls after the 4th foreign comma.
- align_en freeze and async reset:
  - Stimulus: deassert align_en in CHECK, send foreign commas.
  - Required: offset and state unchanged.
  - Stimulus: assert rst mid-LOCKED between clk edges.
  - Required: locked=0 and out=0 immediately, without waiting for a clk edge.
